// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI block master.
package axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW   = 3'd3,
      ST_W    = 3'd4,
      ST_B    = 3'd5,
      ST_DONE = 3'd6
   } axi_mst_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Number of data beats needed to move one block.
   function automatic int unsigned beat_count(input int unsigned block_w,
                                              input int unsigned data_w);
      return block_w / data_w;
   endfunction

   // AxSIZE encoding for a full-width beat.
   function automatic int unsigned axi_size(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/block_beat_buffer.sv
// Block-wide register addressed in bus-width beats: parallel load,
// single-beat insert and single-beat select at the same index.
module block_beat_buffer #(
   parameter int BLOCK_W = 512,
   parameter int DW      = 64,
   parameter int IDX_W   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_en,
   input  logic [BLOCK_W-1:0] load_data,
   input  logic               ins_en,
   input  logic [IDX_W-1:0]   idx,
   input  logic [DW-1:0]      ins_data,
   output logic [BLOCK_W-1:0] block,
   output logic [DW-1:0]      sel_data
);

   logic [BLOCK_W-1:0] block_r;

   // Line storage: load wins over beat insert.
   always_ff @(posedge clk) begin
      if (rst) begin
         block_r <= '0;
      end else if (load_en) begin
         block_r <= load_data;
      end else if (ins_en) begin
         block_r[idx*DW +: DW] <= ins_data;
      end else begin
         block_r <= block_r;
      end
   end

   assign block    = block_r;
   assign sel_data = block_r[idx*DW +: DW];

endmodule

// File: rtl/axi_block_master.sv
// Block-level request to AXI4 INCR burst converter (one line per request).
// Optional build macro: AXI_RESP_CHECK_EN enables the sticky axi_err_o
// flag for non-OKAY responses and misplaced/missing rlast.
module axi_block_master
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH     = 64,
   parameter int BLOCK_WIDTH    = 512,
   parameter int AXI_DATA_WIDTH = 64
) (
   input  logic                        clk_i,
   input  logic                        arst_i,
   input  logic                        axi_read_start_i,
   input  logic                        axi_write_start_i,
   input  logic [ADDR_WIDTH-1:0]       axi_addr_i,
   input  logic [BLOCK_WIDTH-1:0]      data_block_i,
   output logic                        axi_done_o,
   output logic [BLOCK_WIDTH-1:0]      data_block_o,
   output logic                        axi_err_o,
   output logic [ADDR_WIDTH-1:0]       m_araddr_o,
   output logic                        m_arvalid_o,
   input  logic                        m_arready_i,
   output logic [7:0]                  m_arlen_o,
   output logic [2:0]                  m_arsize_o,
   output logic [1:0]                  m_arburst_o,
   input  logic [AXI_DATA_WIDTH-1:0]   m_rdata_i,
   input  logic [1:0]                  m_rresp_i,
   input  logic                        m_rlast_i,
   input  logic                        m_rvalid_i,
   output logic                        m_rready_o,
   output logic [ADDR_WIDTH-1:0]       m_awaddr_o,
   output logic                        m_awvalid_o,
   input  logic                        m_awready_i,
   output logic [7:0]                  m_awlen_o,
   output logic [2:0]                  m_awsize_o,
   output logic [1:0]                  m_awburst_o,
   output logic [AXI_DATA_WIDTH-1:0]   m_wdata_o,
   output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb_o,
   output logic                        m_wlast_o,
   output logic                        m_wvalid_o,
   input  logic                        m_wready_i,
   input  logic [1:0]                  m_bresp_i,
   input  logic                        m_bvalid_i,
   output logic                        m_bready_o
);

   localparam int BEATS = int'(beat_count(BLOCK_WIDTH, AXI_DATA_WIDTH));
   localparam int IDX_W = $clog2(BEATS);
   localparam logic [IDX_W-1:0]      LAST_BEAT = IDX_W'(BEATS - 1);
   localparam logic [IDX_W-1:0]      ONE_BEAT  = IDX_W'(1);
   localparam logic [7:0]            BURST_LEN = 8'(BEATS - 1);
   localparam logic [2:0]            BEAT_SIZE = 3'(axi_size(AXI_DATA_WIDTH));
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);

   axi_mst_state_t        state_r;
   logic [IDX_W-1:0]      beat_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic                  arvalid_r;
   logic                  rready_r;
   logic                  awvalid_r;
   logic                  wvalid_r;
   logic                  wlast_r;
   logic                  bready_r;
   logic                  done_r;

   logic                      rd_ins_s;
   logic                      wr_load_s;
   logic [AXI_DATA_WIDTH-1:0] wr_sel_s;
   logic [AXI_DATA_WIDTH-1:0] rd_sel_unused_s;
   logic [BLOCK_WIDTH-1:0]    wr_block_unused_s;

   // Buffer strobes: capture the write line on AW entry, store each R beat.
   always_comb begin
      rd_ins_s  = 1'b0;
      wr_load_s = 1'b0;
      if (state_r == ST_R) begin
         rd_ins_s = m_rvalid_i;
      end else if (state_r == ST_IDLE) begin
         wr_load_s = axi_write_start_i;
      end else begin
         rd_ins_s  = 1'b0;
         wr_load_s = 1'b0;
      end
   end

   // Read line: holds the last assembled block until the next R beat lands.
   block_beat_buffer #(
      .BLOCK_W (BLOCK_WIDTH),
      .DW      (AXI_DATA_WIDTH),
      .IDX_W   (IDX_W)
   ) u_rd_buf (
      .clk       (clk_i),
      .rst       (arst_i),
      .load_en   (1'b0),
      .load_data ({BLOCK_WIDTH{1'b0}}),
      .ins_en    (rd_ins_s),
      .idx       (beat_r),
      .ins_data  (m_rdata_i),
      .block     (data_block_o),
      .sel_data  (rd_sel_unused_s)
   );

   // Write line: snapshot of data_block_i, walked beat by beat on W.
   block_beat_buffer #(
      .BLOCK_W (BLOCK_WIDTH),
      .DW      (AXI_DATA_WIDTH),
      .IDX_W   (IDX_W)
   ) u_wr_buf (
      .clk       (clk_i),
      .rst       (arst_i),
      .load_en   (wr_load_s),
      .load_data (data_block_i),
      .ins_en    (1'b0),
      .idx       (beat_r),
      .ins_data  ({AXI_DATA_WIDTH{1'b0}}),
      .block     (wr_block_unused_s),
      .sel_data  (wr_sel_s)
   );

   // Transaction FSM with registered channel handshake outputs.
   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         state_r   <= ST_IDLE;
         beat_r    <= '0;
         addr_r    <= '0;
         arvalid_r <= 1'b0;
         rready_r  <= 1'b0;
         awvalid_r <= 1'b0;
         wvalid_r  <= 1'b0;
         wlast_r   <= 1'b0;
         bready_r  <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (axi_write_start_i) begin
                  addr_r    <= axi_addr_i & LINE_MASK;
                  awvalid_r <= 1'b1;
                  state_r   <= ST_AW;
               end else if (axi_read_start_i) begin
                  addr_r    <= axi_addr_i & LINE_MASK;
                  arvalid_r <= 1'b1;
                  state_r   <= ST_AR;
               end
            end
            ST_AR: begin
               if (m_arready_i) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  beat_r    <= '0;
                  state_r   <= ST_R;
               end
            end
            ST_R: begin
               if (m_rvalid_i) begin
                  beat_r <= beat_r + ONE_BEAT;
                  if (beat_r == LAST_BEAT) begin
                     rready_r <= 1'b0;
                     done_r   <= 1'b1;
                     state_r  <= ST_DONE;
                  end
               end
            end
            ST_AW: begin
               if (m_awready_i) begin
                  awvalid_r <= 1'b0;
                  wvalid_r  <= 1'b1;
                  wlast_r   <= 1'b0;
                  beat_r    <= '0;
                  state_r   <= ST_W;
               end
            end
            ST_W: begin
               if (m_wready_i) begin
                  beat_r <= beat_r + ONE_BEAT;
                  if (beat_r == LAST_BEAT) begin
                     wvalid_r <= 1'b0;
                     wlast_r  <= 1'b0;
                     bready_r <= 1'b1;
                     state_r  <= ST_B;
                  end else begin
                     wlast_r <= (beat_r == (LAST_BEAT - ONE_BEAT));
                  end
               end
            end
            ST_B: begin
               if (m_bvalid_i) begin
                  bready_r <= 1'b0;
                  done_r   <= 1'b1;
                  state_r  <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               arvalid_r <= 1'b0;
               rready_r  <= 1'b0;
               awvalid_r <= 1'b0;
               wvalid_r  <= 1'b0;
               wlast_r   <= 1'b0;
               bready_r  <= 1'b0;
               done_r    <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef AXI_RESP_CHECK_EN
   logic err_r;

   // Sticky error: bad response code or rlast not exactly on the final beat.
   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         err_r <= 1'b0;
      end else if ((state_r == ST_R) && m_rvalid_i &&
                   ((m_rresp_i != AXI_RESP_OKAY) || (m_rlast_i != (beat_r == LAST_BEAT)))) begin
         err_r <= 1'b1;
      end else if ((state_r == ST_B) && m_bvalid_i && (m_bresp_i != AXI_RESP_OKAY)) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign axi_err_o = err_r;
`else
   logic resp_unused_s;

   assign resp_unused_s = ^{m_rresp_i, m_rlast_i, m_bresp_i};
   assign axi_err_o     = 1'b0;
`endif

   assign axi_done_o  = done_r;
   assign m_araddr_o  = addr_r;
   assign m_arvalid_o = arvalid_r;
   assign m_arlen_o   = BURST_LEN;
   assign m_arsize_o  = BEAT_SIZE;
   assign m_arburst_o = AXI_BURST_INCR;
   assign m_rready_o  = rready_r;
   assign m_awaddr_o  = addr_r;
   assign m_awvalid_o = awvalid_r;
   assign m_awlen_o   = BURST_LEN;
   assign m_awsize_o  = BEAT_SIZE;
   assign m_awburst_o = AXI_BURST_INCR;
   assign m_wdata_o   = wr_sel_s;
   assign m_wstrb_o   = {(AXI_DATA_WIDTH/8){1'b1}};
   assign m_wlast_o   = wlast_r;
   assign m_wvalid_o  = wvalid_r;
   assign m_bready_o  = bready_r;

endmodule
